gctr_seq_ctrl: RTL and testbench

GCTR_SEQ_CTRL -- requirements
Module: gctr_seq_ctrl

---
 rtl/gctr_pkg.sv | 19 +
 rtl/gctr_inc32.sv | 13 +
 rtl/gctr_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_gctr_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gctr_pkg.sv
// Shared types and helpers for the GCTR sequencing controller.
package gctr_pkg;

  localparam int unsigned BlockWidth = 128;

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StCipher,
    StOutput,
    StDone
  } gctr_state_e;

  // Standard GCM counter step: only the low 32 bits advance, wrapping silently.
  function automatic logic [31:0] inc32(input logic [31:0] ctr);
    return ctr + 32'd1;
  endfunction

endpackage

// File: rtl/gctr_inc32.sv
// Combinational GCM counter-block increment (low 32 bits only).
module gctr_inc32
  import gctr_pkg::*;
#(
  parameter int unsigned ICB_WIDTH = 128
) (
  input  logic [ICB_WIDTH-1:0] cb_i,
  output logic [ICB_WIDTH-1:0] cb_o
);

  assign cb_o = {cb_i[ICB_WIDTH-1:32], inc32(cb_i[31:0])};

endmodule

// File: rtl/gctr_seq_ctrl.sv
// GCTR message sequencer: feeds counter blocks to an external AES core and XORs the keystream.
// Optional GCTR_PARTIAL_BLOCK_EN zeroes the unused tail bytes of the final block.
module gctr_seq_ctrl
  import gctr_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = BlockWidth,
  parameter int unsigned ICB_WIDTH   = 128,
  parameter int unsigned NBLK_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ICB_WIDTH-1:0]   icb,
  input  logic [NBLK_WIDTH-1:0]  nblk,
  input  logic [3:0]             last_bytes,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLOCK_WIDTH-1:0] in_data,
  output logic                   aes_start,
  output logic [ICB_WIDTH-1:0]   aes_cb,
  input  logic                   aes_done,
  input  logic [BLOCK_WIDTH-1:0] aes_ks,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_WIDTH-1:0] out_data,
  output logic                   busy,
  output logic                   done
);

  gctr_state_e            state_q, state_d;
  logic [ICB_WIDTH-1:0]   cb_q, cb_d, cb_inc;
  logic [NBLK_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
  logic [BLOCK_WIDTH-1:0] out_q, out_d;
  logic                   aes_start_q, aes_start_d;
  logic [BLOCK_WIDTH-1:0] keep_mask;
  logic                   last_blk;

  gctr_inc32 #(
    .ICB_WIDTH(ICB_WIDTH)
  ) u_inc32 (
    .cb_i(cb_q),
    .cb_o(cb_inc)
  );

  // cnt holds the blocks still to be emitted, including the one in flight.
  assign last_blk = (cnt_q == NBLK_WIDTH'(1));

`ifdef GCTR_PARTIAL_BLOCK_EN
  logic [3:0] lb_q, lb_d;

  always_comb begin
    keep_mask = '1;
    if (last_blk && (lb_q != 4'd0)) begin
      keep_mask = ~({BLOCK_WIDTH{1'b1}} >> {lb_q, 3'b000});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_q <= 4'd0;
    end else begin
      lb_q <= lb_d;
    end
  end

  always_comb begin
    lb_d = lb_q;
    if ((state_q == StIdle) && start) begin
      lb_d = last_bytes;
    end
  end
`else
  logic unused_last_bytes;
  assign unused_last_bytes = ^{last_bytes, last_blk};
  assign keep_mask = '1;
`endif

  always_comb begin
    state_d     = state_q;
    cb_d        = cb_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    out_d       = out_q;
    aes_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cb_d    = icb;
          cnt_d   = nblk;
          state_d = (nblk == '0) ? StDone : StWaitData;
        end
      end
      StWaitData: begin
        if (in_valid) begin
          blk_d       = in_data;
          aes_start_d = 1'b1;
          state_d     = StCipher;
        end
      end
      StCipher: begin
        if (aes_done) begin
          out_d   = (blk_q ^ aes_ks) & keep_mask;
          state_d = StOutput;
        end
      end
      StOutput: begin
        if (out_ready) begin
          cb_d    = cb_inc;
          cnt_d   = cnt_q - NBLK_WIDTH'(1);
          state_d = last_blk ? StDone : StWaitData;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cb_q        <= '0;
      cnt_q       <= '0;
      blk_q       <= '0;
      out_q       <= '0;
      aes_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cb_q        <= cb_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      out_q       <= out_d;
      aes_start_q <= aes_start_d;
    end
  end

  assign in_ready  = (state_q == StWaitData);
  assign out_valid = (state_q == StOutput);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign aes_start = aes_start_q;
  assign aes_cb    = cb_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_gctr_seq_ctrl.sv
// Randomised scoreboard bench for gctr_seq_ctrl with a behavioural AES stub.
module tb_gctr_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] icb;
  logic [15:0]  nblk;
  logic [3:0]   last_bytes;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         aes_start;
  logic [127:0] aes_cb;
  logic         aes_done;
  logic [127:0] aes_ks;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         busy, done;

  always #5 clk = ~clk;

  gctr_seq_ctrl #(
    .BLOCK_WIDTH(128),
    .ICB_WIDTH  (128),
    .NBLK_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .icb       (icb),
    .nblk      (nblk),
    .last_bytes(last_bytes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .aes_start (aes_start),
    .aes_cb    (aes_cb),
    .aes_done  (aes_done),
    .aes_ks    (aes_ks),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_aes_start = 0;
  int n_done = 0;
  int n_in_ready = 0;
  bit ks_identity = 1'b0;
  bit hold_ready = 1'b0;
  int stub_delay = -1;

  logic [127:0] cb_exp[$];
  logic [127:0] out_exp[$];

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stub keystream: identity or a fixed scramble of the counter block.
  function automatic logic [127:0] ks_fn(input logic [127:0] cb);
    if (ks_identity) return cb;
    return {cb[63:0] ^ 64'hC3A5_5A3C_0F1E_2D4B, cb[127:64]} ^ {4{cb[31:0] * 32'h9E37_79B9}};
  endfunction

  // Model of the counter: GCM inc32 applied i times.
  function automatic logic [127:0] model_cb(input logic [127:0] icb_v, input int i);
    logic [31:0] lo;
    lo = icb_v[31:0] + 32'(i);
    return {icb_v[127:32], lo};
  endfunction

`ifdef GCTR_PARTIAL_BLOCK_EN
  function automatic logic [127:0] model_mask(input logic [127:0] v, input logic [3:0] lb);
    int keep;
    keep = (lb == 4'd0) ? 16 : int'(lb);
    for (int b = 0; b < 16; b++) if (b >= keep) v[127-8*b -: 8] = 8'h00;
    return v;
  endfunction
`endif

  // Out-ready driver: random unless held low.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // AES stub: captures aes_cb on aes_start, returns the keystream after a delay.
  initial begin
    logic [127:0] cap;
    aes_done = 1'b0;
    aes_ks   = '0;
    forever begin
      @(negedge clk);
      if (aes_start) begin
        n_aes_start++;
        cap = aes_cb;
        if (cb_exp.size() == 0) check(1'b0, "unexpected aes_start", aes_cb, '0);
        else begin
          logic [127:0] e;
          e = cb_exp.pop_front();
          check(aes_cb == e, "aes_cb", aes_cb, e);
        end
        repeat ((stub_delay >= 0) ? stub_delay : int'($urandom_range(0, 3))) @(negedge clk);
        if (busy) check(aes_cb == cap, "aes_cb stable in cipher", aes_cb, cap);
        aes_done = 1'b1;
        aes_ks   = ks_fn(cap);
        @(negedge clk);
        aes_done = 1'b0;
        aes_ks   = rand128();
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    bit           prev_hold = 1'b0;
    logic [127:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_ready) n_in_ready++;
        if (done) n_done++;
        if (out_valid) begin
          if (prev_hold) check(out_data == prev_data, "out_data stable", out_data, prev_data);
          if (out_ready) begin
            if (out_exp.size() == 0) check(1'b0, "unexpected output", out_data, '0);
            else begin
              logic [127:0] e;
              e = out_exp.pop_front();
              check(out_data == e, "out_data", out_data, e);
            end
          end
          prev_hold = !out_ready;
          prev_data = out_data;
        end else begin
          prev_hold = 1'b0;
        end
      end
    end
  end

  task automatic send_msg(input logic [127:0] icb_v, input int n, input logic [3:0] lb,
                          input bit zero_data);
    logic [127:0] data[$];
    int starts0, ready0, done0, k;
    bit found;
    for (int i = 0; i < n; i++) begin
      logic [127:0] d, e, cb;
      d  = zero_data ? 128'd0 : rand128();
      cb = model_cb(icb_v, i);
      e  = d ^ ks_fn(cb);
`ifdef GCTR_PARTIAL_BLOCK_EN
      if (i == n - 1) e = model_mask(e, lb);
`endif
      data.push_back(d);
      cb_exp.push_back(cb);
      out_exp.push_back(e);
    end
    starts0 = n_aes_start;
    ready0  = n_in_ready;
    done0   = n_done;
    @(posedge clk);
    #1;
    start = 1'b1; icb = icb_v; nblk = 16'(n); last_bytes = lb;
    @(posedge clk);
    #1;
    start = 1'b0; icb = rand128(); nblk = 16'($urandom()); last_bytes = 4'($urandom());
    @(negedge clk);
    check(busy == 1'b1, "busy after start", 128'(busy), 128'd1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk);
      #1;
      // start pulses while busy must be ignored
      in_valid = 1'b1; in_data = data[i]; start = 1'b1;
      found = 1'b0;
      for (k = 0; k < 300; k++) begin
        @(negedge clk);
        if (in_ready) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) check(1'b0, "in_ready timeout", 128'(i), 128'(n));
      @(posedge clk);
      #1;
      in_valid = 1'b0; start = 1'b0; in_data = rand128();
      if (!found) return;
    end
    found = (n_done != done0);
    for (k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      found = (n_done != done0);
    end
    check(found, "done pulse", 128'(found), 128'd1);
    if (n == 0) begin
      check(k <= 2, "empty msg done latency", 128'(k), 128'd2);
      check(n_in_ready == ready0, "empty msg in_ready", 128'(n_in_ready - ready0), 128'd0);
    end
    check(n_aes_start - starts0 == n, "aes_start count", 128'(n_aes_start - starts0), 128'(n));
    @(negedge clk);
    check(!done && !busy, "done one cycle then idle", {done, busy}, 128'd0);
    check(out_exp.size() == 0, "scoreboard drained", 128'(out_exp.size()), 128'd0);
  endtask

  task automatic bp_check();
    bit found = 1'b0;
    logic [127:0] d0;
    int s0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      found = out_valid;
    end
    check(found, "backpressure out_valid", 128'(found), 128'd1);
    d0 = out_data;
    s0 = n_aes_start;
    repeat (5) begin
      @(negedge clk);
      check(out_valid && out_data == d0 && !in_ready && n_aes_start == s0,
            "backpressure hold", out_data, d0);
    end
    hold_ready = 1'b0;
  endtask

  task automatic reset_mid_message();
    bit found = 1'b0;
    int s0;
    stub_delay = 8;
    cb_exp.push_back(model_cb(128'h1234, 0));
    s0 = n_aes_start;
    @(posedge clk);
    #1;
    start = 1'b1; icb = 128'h1234; nblk = 16'd2; last_bytes = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b1; in_data = rand128();
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      found = in_ready;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check(n_aes_start == s0 + 1 && busy, "reach cipher", 128'(n_aes_start - s0), 128'd1);
    #1;
    rst = 1'b1;
    #1;
    check({in_ready, aes_start, out_valid, busy, done} == 5'd0, "outputs in reset",
          {in_ready, aes_start, out_valid, busy, done}, 128'd0);
    check(aes_cb == '0 && out_data == '0, "data outputs in reset", aes_cb | out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check(!out_valid && !busy && !in_ready, "idle after reset",
            {out_valid, busy, in_ready}, 128'd0);
    end
    cb_exp.delete();
    out_exp.delete();
    stub_delay = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; icb = '0; nblk = '0; last_bytes = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({in_ready, aes_start, out_valid, busy, done} == 5'd0, "reset outputs",
          {in_ready, aes_start, out_valid, busy, done}, 128'd0);
    check(aes_cb == '0 && out_data == '0, "reset data outputs", aes_cb | out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    send_msg(rand128(), 0, 4'd0, 1'b0);

    ks_identity = 1'b1;
    send_msg(128'h1, 3, 4'd0, 1'b1);
    ks_identity = 1'b0;

    send_msg({{12{8'hA5}}, 32'hFFFF_FFFF}, 2, 4'd0, 1'b0);

    hold_ready = 1'b1;
    fork
      send_msg(rand128(), 2, 4'd0, 1'b0);
      bp_check();
    join

    for (int m = 0; m < 8; m++) begin
      send_msg(rand128(), int'($urandom_range(1, 5)), 4'($urandom()), 1'b0);
    end

`ifdef GCTR_PARTIAL_BLOCK_EN
    send_msg(rand128(), 1, 4'd5, 1'b0);
`endif

    reset_mid_message();
    send_msg(rand128(), 2, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
